// File: rtl/ecc_fifo_pkg.sv
// Opcodes, FSM state encoding and sizing defaults shared by the ECC FIFO dispatcher.
package ecc_fifo_pkg;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SQR  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT,
    ST_PUSH
  } state_t;

  // Two-operand opcodes take their second operand from FIFO B.
  function automatic logic op_needs_b(input logic [1:0] op);
    return (op == OP_MUL) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/fifo_occ_tracker.sv
// Saturating occupancy counter that shadows one FIFO from its push/pop strobes.
module fifo_occ_tracker #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !pop && count != FULL) begin
      count <= count + 1'b1;
    end else if (pop && !push && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ecc_fifo_dispatcher.sv
// Pops a command plus operands from the FIFO block, runs one AU job at a time
// and pushes the result into FIFO C, tracking FIFO occupancy from the strobes.
module ecc_fifo_dispatcher
  import ecc_fifo_pkg::*;
#(
  parameter int DATA    = 256,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_A,
  input  logic            wr_en_B,
  input  logic            wr_en_D,
  input  logic            rd_en_C_ext,
  output logic            rd_en_A,
  output logic            rd_en_B,
  output logic            rd_en_D,
  input  logic [DATA-1:0] Data_out_A,
  input  logic [DATA-1:0] Data_out_B,
  input  logic [DATA-1:0] Data_out_D,
  output logic            wr_en_C,
  output logic [DATA-1:0] Data_in_C,
  output logic            au_start,
  output logic [1:0]      au_op,
  output logic [DATA-1:0] au_a,
  output logic [DATA-1:0] au_b,
  input  logic            au_done,
  input  logic [DATA-1:0] au_result,
  output logic            busy,
  output logic            err_timeout
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t          state_reg;
  logic [TW-1:0]   timer_reg;
  logic [3:0]      push_v;
  logic [3:0]      pop_v;
  logic [CW-1:0]   occ [4];
  logic            ready;
  logic            room_c;
  logic            d_unused;

  // Tracker index: 0 = A, 1 = B, 2 = D, 3 = C.
  assign push_v = {wr_en_C, wr_en_D, wr_en_B, wr_en_A};
  assign pop_v  = {rd_en_C_ext, rd_en_D, rd_en_B, rd_en_A};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_occ
      fifo_occ_tracker #(.DEPTH(DEPTH)) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_v[gi]),
        .pop   (pop_v[gi]),
        .count (occ[gi])
      );
    end
  endgenerate

  // The opcode is unknown until D is popped, so B is always required and consumed.
  assign ready    = (occ[0] != '0) && (occ[1] != '0) && (occ[2] != '0);
  // A same-cycle downstream pop frees a slot in C in time for our push.
  assign room_c   = (occ[3] != FULL) || rd_en_C_ext;
  assign busy     = (state_reg != ST_IDLE);
  assign d_unused = ^Data_out_D[DATA-1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      rd_en_A     <= 1'b0;
      rd_en_B     <= 1'b0;
      rd_en_D     <= 1'b0;
      wr_en_C     <= 1'b0;
      au_start    <= 1'b0;
      au_op       <= '0;
      au_a        <= '0;
      au_b        <= '0;
      Data_in_C   <= '0;
      err_timeout <= 1'b0;
    end else begin
      rd_en_A  <= 1'b0;
      rd_en_B  <= 1'b0;
      rd_en_D  <= 1'b0;
      au_start <= 1'b0;
      wr_en_C  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ready) begin
            rd_en_A   <= 1'b1;
            rd_en_B   <= 1'b1;
            rd_en_D   <= 1'b1;
            state_reg <= ST_POP;
          end
        end
        ST_POP: begin
          state_reg <= ST_LATCH;
        end
        ST_LATCH: begin
          au_op     <= Data_out_D[1:0];
          au_a      <= Data_out_A;
          au_b      <= op_needs_b(Data_out_D[1:0]) ? Data_out_B : '0;
          au_start  <= 1'b1;
          state_reg <= ST_ISSUE;
        end
        ST_ISSUE: begin
          timer_reg <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (au_done) begin
            Data_in_C <= au_result;
            wr_en_C   <= room_c;
            state_reg <= ST_PUSH;
          end else if (timer_reg == T_LAST) begin
            err_timeout <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_PUSH: begin
          // wr_en_C high here means the push has just been issued.
          if (wr_en_C) begin
            state_reg <= ST_IDLE;
          end else begin
            wr_en_C <= room_c;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ecc_fifo_dispatcher.md
Name: ecc_fifo_dispatcher

Overview:
- Sequencer between the four-FIFO buffer block and the ECC arithmetic unit.
- Each job pops one command word from FIFO D and one or two operands from FIFOs A and B, then launches the arithmetic unit and waits for its done pulse.
- Pushes the result into FIFO C.
- The FIFO block exposes no empty flag, so this block tracks occupancy of A, B, D and C by snooping push/pop strobes.

Parameters:
- DATA, 256, FIFO word width and operand/result width.
- DEPTH, 8, FIFO depth in words; occupancy counters are $clog2(DEPTH)+1 bits.
- TIMEOUT, 1023, maximum WAIT cycles before the job is aborted.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en_A / wr_en_B / wr_en_D  in  1 each  upstream pushes into A/B/D (snooped)
- rd_en_C_ext  in  1  downstream pop of C (snooped)
- rd_en_A / rd_en_B / rd_en_D  out  1 each  pop strobes to the FIFO block
- Data_out_A / Data_out_B / Data_out_D  in  DATA each  FIFO read data, valid 1 cycle after the pop
- wr_en_C  out  1  push strobe to FIFO C
- Data_in_C  out  DATA  result word to FIFO C
- au_start  out  1  one-cycle launch pulse to the arithmetic unit
- au_op  out  2  opcode: 0 MUL, 1 ADD, 2 SQR, 3 PASS
- au_a / au_b  out  DATA each  operands, held stable from au_start to au_done
- au_done  in  1  one-cycle completion pulse
- au_result  in  DATA  result, valid with au_done
- busy  out  1  high whenever state != IDLE
- err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async, rst_n low):
  - all occupancy counters 0; state IDLE.
  - all strobes 0; au_op, au_a, au_b and Data_in_C all 0.
  - busy 0; err_timeout 0.
- Occupancy counters:
  - occ_X += push, -= pop, every cycle.
  - A simultaneous push and pop leaves the count unchanged.
  - Saturate at 0 and DEPTH; never wrap.
- Command decode, from Data_out_D[1:0]:
  - MUL and ADD need one word from A and one from B.
  - SQR and PASS need A only; au_b is driven 0.
- IDLE -> POP:
  - Condition: occ_D >= 1, occ_A >= 1, and occ_B >= 1 whenever the pending opcode needs B.
  - The opcode is not known before the D pop, so POP requires occ_B >= 1 unconditionally. Consequence: SQR/PASS stall while B is empty.
- POP (1 cycle):
  - Assert rd_en_D and rd_en_A.
  - Assert rd_en_B; it is not popped back. Consequence: every job consumes one B word, and for SQR/PASS that word is discarded.
  - Go to LATCH.
- LATCH (1 cycle):
  - Capture Data_out_D[1:0] into au_op, Data_out_A into au_a, and Data_out_B (or 0) into au_b.
  - Go to ISSUE.
- ISSUE (1 cycle): au_start=1; go to WAIT.
- WAIT:
  - On au_done: capture au_result into Data_in_C and go to PUSH.
  - Timeout counter reaches TIMEOUT: set err_timeout, drop the job with no C push, and go to IDLE.
- PUSH:
  - If occ_C < DEPTH: wr_en_C=1 for exactly one cycle, then IDLE.
  - Otherwise hold in PUSH with Data_in_C stable until occ_C < DEPTH.
- Latency, launch to result:
  - Best case, IDLE to au_start = 3 cycles (POP, LATCH, ISSUE).
  - au_done to wr_en_C = 1 cycle.
- Pulse widths: all strobes are single-cycle; there is never more than one job in flight.
- Edge cases:
  - au_done outside WAIT is ignored.
  - au_done and timeout in the same cycle: au_done wins.
- Mid-operation reset: immediate return to IDLE. FIFO contents are outside this block, so occupancy counters must be reset together with the FIFO block.

Decomposition:
- Shared package ecc_fifo_pkg: opcode localparams OP_MUL=0, OP_ADD=1, OP_SQR=2, OP_PASS=3; state encoding; DEPTH default.
- Sub-module fifo_occ_tracker: one saturating occupancy counter with push, pop and count; instantiated four times.

Test Plan:
- Push A=5, B=7, D=OP_MUL once; AU answers done with 35 after 4 cycles -> rd_en_A/B/D pulse in the same cycle; au_start 2 cycles later with au_a=5, au_b=7; wr_en_C 1 cycle after done with Data_in_C=35.
- D=OP_SQR, A=9, B=1 -> au_b=0, au_op=2; occ_B decrements to 0 (B word discarded).
- Pre-fill occ_C to 8 with no rd_en_C_ext; one job completes -> holds in PUSH, wr_en_C=0; pulse rd_en_C_ext once -> wr_en_C next cycle.
- AU never asserts done -> err_timeout=1 after 1023 WAIT cycles; no C push; next queued job proceeds normally.
- Push 8 words into A, then simultaneously push and pop A for 5 cycles -> occ_A stays 8, never 9.
- Assert rst_n=0 during WAIT -> busy=0 and au_start=0 immediately; err_timeout=0; no wr_en_C after release.
